// File: rtl/frog_autoplayer.sv
// Frog game autoplayer: waits for a free lane, double-presses go, then advances two lanes.
// Define FROG_AUTOPLAYER_BACKOFF_EN to add a timed back press when a lane stays blocked.
module frog_autoplayer #(
    parameter int PULSE_LEN    = 24,
    parameter int GAP_LEN      = 24,
    parameter int HOLDOFF      = 110000,
    parameter int WAIT_TIMEOUT = 200000,
    parameter int LAST_IDX     = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [17:0] outview,
    output logic        go_n,
    output logic        back_n,
    output logic [4:0]  cursor,
    output logic        busy,
    output logic        done
);

    // state     | meaning
    // IDLE      | parked, cursor held, waiting for enable
    // WAIT_FREE | waiting for outview[cursor] to read free
    // GO_LO1    | first go press, go_n low
    // GO_HI     | gap between the two presses
    // GO_LO2    | second go press, go_n low
    // HOLD      | settle time after the double press
    // BACK_LO   | back press, back_n low (backoff builds)
    // BACK_HI   | release after the back press (backoff builds)
    // DONE      | all lanes crossed, sticky until rst

    localparam int MAX_PG  = (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
    localparam int MAX_LEN = (MAX_PG > HOLDOFF) ? MAX_PG : HOLDOFF;
    localparam int CW      = $clog2(MAX_LEN + 1);

    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_LEN - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_LEN - 1);
    localparam logic [CW-1:0] HOLD_LD  = CW'(HOLDOFF - 1);
    localparam logic [5:0]    LAST6    = 6'(LAST_IDX);

    typedef enum logic [3:0] {
        IDLE,
        WAIT_FREE,
        GO_LO1,
        GO_HI,
        GO_LO2,
        HOLD,
        DONE
`ifdef FROG_AUTOPLAYER_BACKOFF_EN
        , BACK_LO,
        BACK_HI
`endif
    } state_t;

    state_t        state;
    logic [CW-1:0] phase_cnt;
    logic [31:0]   view_ext;
    logic          lane_free;
    logic [5:0]    cursor_adv;

    // Lanes past the end of the view read as free; the cursor never waits there.
    assign view_ext   = {14'd0, outview};
    assign lane_free  = ~view_ext[cursor];
    assign cursor_adv = {1'b0, cursor} + 6'd2;

`ifdef FROG_AUTOPLAYER_BACKOFF_EN
    localparam int          WW        = $clog2(WAIT_TIMEOUT + 1);
    localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_TIMEOUT - 1);
    logic [WW-1:0] wait_cnt;
`else
    assign back_n = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cursor    <= 5'd1;
            go_n      <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            phase_cnt <= '0;
`ifdef FROG_AUTOPLAYER_BACKOFF_EN
            back_n    <= 1'b1;
            wait_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= WAIT_FREE;
                        busy  <= 1'b1;
`ifdef FROG_AUTOPLAYER_BACKOFF_EN
                        wait_cnt <= '0;
`endif
                    end
                end
                WAIT_FREE: begin
                    // A free lane takes priority over a dropped enable.
                    if (lane_free) begin
                        state     <= GO_LO1;
                        go_n      <= 1'b0;
                        phase_cnt <= PULSE_LD;
`ifdef FROG_AUTOPLAYER_BACKOFF_EN
                        wait_cnt  <= '0;
`endif
                    end else if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
`ifdef FROG_AUTOPLAYER_BACKOFF_EN
                    else if (wait_cnt == WAIT_LAST) begin
                        state     <= BACK_LO;
                        back_n    <= 1'b0;
                        phase_cnt <= PULSE_LD;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
`endif
                end
                GO_LO1: begin
                    if (phase_cnt == '0) begin
                        state     <= GO_HI;
                        go_n      <= 1'b1;
                        phase_cnt <= GAP_LD;
                    end else begin
                        phase_cnt <= phase_cnt - CW'(1);
                    end
                end
                GO_HI: begin
                    if (phase_cnt == '0) begin
                        state     <= GO_LO2;
                        go_n      <= 1'b0;
                        phase_cnt <= PULSE_LD;
                    end else begin
                        phase_cnt <= phase_cnt - CW'(1);
                    end
                end
                GO_LO2: begin
                    if (phase_cnt == '0) begin
                        state     <= HOLD;
                        go_n      <= 1'b1;
                        phase_cnt <= HOLD_LD;
                    end else begin
                        phase_cnt <= phase_cnt - CW'(1);
                    end
                end
                HOLD: begin
                    if (phase_cnt == '0) begin
                        cursor <= cursor_adv[4:0];
                        if (cursor_adv > LAST6) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= WAIT_FREE;
`ifdef FROG_AUTOPLAYER_BACKOFF_EN
                            wait_cnt <= '0;
`endif
                        end
                    end else begin
                        phase_cnt <= phase_cnt - CW'(1);
                    end
                end
`ifdef FROG_AUTOPLAYER_BACKOFF_EN
                BACK_LO: begin
                    if (phase_cnt == '0) begin
                        state     <= BACK_HI;
                        back_n    <= 1'b1;
                        phase_cnt <= GAP_LD;
                    end else begin
                        phase_cnt <= phase_cnt - CW'(1);
                    end
                end
                BACK_HI: begin
                    if (phase_cnt == '0) begin
                        state    <= WAIT_FREE;
                        wait_cnt <= '0;
                        if (cursor >= 5'd3) begin
                            cursor <= cursor - 5'd2;
                        end
                    end else begin
                        phase_cnt <= phase_cnt - CW'(1);
                    end
                end
`endif
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                    go_n  <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frog_autoplayer.sv
// Directed bench for frog_autoplayer with short phase lengths.
module tb_frog_autoplayer;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [17:0] outview;
    logic        go_n;
    logic        back_n;
    logic [4:0]  cursor;
    logic        busy;
    logic        done;

    int checks = 0;
    int passed = 0;
    logic both_low_seen = 1'b0;

    frog_autoplayer #(
        .PULSE_LEN   (4),
        .GAP_LEN     (4),
        .HOLDOFF     (10),
        .WAIT_TIMEOUT(20),
        .LAST_IDX    (17)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .outview(outview),
        .go_n   (go_n),
        .back_n (back_n),
        .cursor (cursor),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!go_n && !back_n) both_low_seen = 1'b1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            passed++;
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_cursor(input logic [4:0] target, input int budget);
        int n;
        n = 0;
        while (cursor != target && n < budget) begin
            step(1);
            n++;
        end
    endtask

    initial begin
        logic [11:0] pat;
        logic        ok;
        logic        prev;
        int          falls;
        int          n;

        rst = 1'b1; enable = 1'b0; outview = '0;
        step(2);
        check("rst_go_n", go_n, 1);
        check("rst_back_n", back_n, 1);
        check("rst_cursor", cursor, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);

        // Free road: full run of nine double presses.
        rst = 1'b0; enable = 1'b1;
        step(1);
        check("wf_busy", busy, 1);
        check("wf_go_n", go_n, 1);
        step(1);
        check("lo1_go_n", go_n, 0);
        check("lo1_cursor", cursor, 1);
        for (int i = 0; i < 12; i++) begin
            pat[i] = go_n;
            step(1);
        end
        check("press_shape", pat, 12'h0F0);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (!go_n || cursor != 5'd1 || !busy) ok = 1'b0;
            step(1);
        end
        check("hold_idle", ok, 1);
        check("cursor_adv", cursor, 3);
        check("wf2_go_n", go_n, 1);
        falls = 0;
        prev  = go_n;
        n     = 0;
        while (!done && n < 400) begin
            step(1);
            if (prev && !go_n) falls++;
            prev = go_n;
            n++;
        end
        check("remaining_pulses", falls, 16);
        check("done_set", done, 1);
        check("done_cursor", cursor, 19);
        check("done_busy", busy, 0);
        enable = 1'b0;
        step(3);
        enable = 1'b1; outview = 18'h3FFFF;
        step(3);
        check("done_sticky", done, 1);
        check("done_go_n", go_n, 1);

        // Blocked lane 1 for a while, then freed.
        rst = 1'b1;
        step(1);
        check("rst_clears_done", done, 0);
        rst = 1'b0; enable = 1'b1; outview = 18'h2;
        step(1);
        ok = 1'b1;
        for (int i = 0; i < 15; i++) begin
            step(1);
            if (!go_n) ok = 1'b0;
        end
        check("blocked_go_high", ok, 1);
        outview = '0;
        step(1);
        check("freed_go_low", go_n, 0);
        check("freed_cursor", cursor, 1);

        // Reset on the second cycle of GO_LO2.
        step(3);
        step(4);
        step(2);
        check("lo2_c2_go_n", go_n, 0);
        rst = 1'b1; enable = 1'b0;
        step(1);
        check("midrst_go_n", go_n, 1);
        check("midrst_cursor", cursor, 1);
        check("midrst_busy", busy, 0);
        rst = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(1);
            if (!go_n || busy) ok = 1'b0;
        end
        check("no_resume", ok, 1);

        // Drop enable while waiting at cursor 5.
        enable = 1'b1; outview = 18'h20;
        wait_cursor(5'd5, 200);
        check("reach5", cursor, 5);
        step(2);
        check("wait5_go_n", go_n, 1);
        check("wait5_busy", busy, 1);
        enable = 1'b0;
        step(1);
        check("idle5_busy", busy, 0);
        check("idle5_cursor", cursor, 5);
        step(3);
        check("idle5_keep", cursor, 5);
        outview = '0; enable = 1'b1;
        step(1);
        check("reen_busy", busy, 1);
        step(1);
        check("reen_go_n", go_n, 0);
        check("reen_cursor", cursor, 5);

        // Long block at cursor 5.
        rst = 1'b1;
        step(1);
        rst = 1'b0; enable = 1'b1; outview = 18'h20;
        wait_cursor(5'd5, 200);
        check("bk_reach5", cursor, 5);
`ifdef FROG_AUTOPLAYER_BACKOFF_EN
        step(19);
        check("pre_timeout_back", back_n, 1);
        step(1);
        check("back_lo", back_n, 0);
        check("back_go_n", go_n, 1);
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            if (back_n) ok = 1'b0;
        end
        check("back_lo_len", ok, 1);
        step(1);
        check("back_hi", back_n, 1);
        check("back_hi_cursor", cursor, 5);
        step(4);
        check("back_cursor", cursor, 3);
        step(1);
        check("back_then_press", go_n, 0);
`else
        ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (!back_n || cursor != 5'd5 || !go_n) ok = 1'b0;
        end
        check("no_backoff_wait", ok, 1);
        check("no_backoff_busy", busy, 1);
`endif

        check("never_both_low", both_low_seen, 0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/frog_autoplayer.md
FROG_AUTOPLAYER -- requirements
Module: frog_autoplayer

Interface
REQ-001 SHALL provide parameter PULSE_LEN, default 24, cycles a button is held low per press.
REQ-002 SHALL provide parameter GAP_LEN, default 24, cycles high between the two presses of a double press.
REQ-003 SHALL provide parameter HOLDOFF, default 110000, cycles idle after a double press before the next lane check.
REQ-004 SHALL provide parameter WAIT_TIMEOUT, default 200000, blocked-wait cycles before a back press (backoff builds only).
REQ-005 SHALL provide parameter LAST_IDX, default 17, highest lane index the player targets.
REQ-006 SHALL have port clk  input  1  single clock for all logic.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port enable  input  1  1 = player may start or continue waiting.
REQ-009 SHALL have port outview  input  18  game lane view; bit value 0 = cell free.
REQ-010 SHALL have port go_n  output  1  active-low go button to game.
REQ-011 SHALL have port back_n  output  1  active-low back button to game.
REQ-012 SHALL have port cursor  output  5  lane index currently targeted.
REQ-013 SHALL have port busy  output  1  high in any state except IDLE and DONE.
REQ-014 SHALL have port done  output  1  high in DONE.

Function
REQ-015 SHALL implement states IDLE, WAIT_FREE, GO_LO1, GO_HI, GO_LO2, HOLD, BACK_LO, BACK_HI, DONE; all outputs registered.
REQ-016 IDLE: cursor holds; enable=1 at an edge -> WAIT_FREE next cycle.
REQ-017 WAIT_FREE: outview[cursor]=0 at an edge -> GO_LO1 next cycle, go_n=0 from that cycle.
REQ-018 WAIT_FREE with enable=0 and lane blocked -> IDLE, cursor kept; a free lane wins over enable=0 on the same edge.
REQ-019 GO_LO1 SHALL last exactly PULSE_LEN cycles with go_n=0, then GO_HI for GAP_LEN cycles with go_n=1, then GO_LO2 for PULSE_LEN cycles with go_n=0.
REQ-020 HOLD SHALL last HOLDOFF cycles with go_n=1; on exit cursor += 2.
REQ-021 Exit of HOLD: new cursor > LAST_IDX -> DONE; else WAIT_FREE.
REQ-022 Once started, a press sequence GO_LO1..HOLD SHALL complete regardless of enable or outview changes.
REQ-023 DONE SHALL be sticky until rst; go_n=back_n=1.
REQ-024 go_n and back_n SHALL never be low in the same cycle.
REQ-025 Phase counters SHALL be wide enough for the largest parameter; no wrap inside a phase.

Reset
REQ-026 rst=1 at an edge SHALL force state IDLE, cursor=1, go_n=1, back_n=1, busy=0, done=0, all counters 0, from the next cycle.
REQ-027 rst mid-press SHALL release the button on the next edge; no truncated pulse resumes after reset.

Configuration
REQ-028 Macro FROG_AUTOPLAYER_BACKOFF_EN defined: WAIT_FREE counts blocked cycles; count reaching WAIT_TIMEOUT -> BACK_LO (back_n=0, PULSE_LEN cycles) -> BACK_HI (back_n=1, GAP_LEN cycles) -> WAIT_FREE, counter cleared, cursor -= 2 if cursor >= 3 else unchanged.
REQ-029 Macro undefined: no wait counter, BACK_LO/BACK_HI absent, back_n tied 1, WAIT_FREE waits indefinitely.
REQ-030 Blocked-wait counter SHALL clear on every WAIT_FREE entry and on a free lane.

Verification (PULSE_LEN=4, GAP_LEN=4, HOLDOFF=10, WAIT_TIMEOUT=20, LAST_IDX=17)
REQ-031 rst, enable=1, outview=0 -> go_n low 4 cycles, high 4, low 4, then 10 idle, cursor 1->3; nine double presses total, then done=1 with cursor=19.
REQ-032 outview[1]=1 held 15 cycles then 0 -> go_n stays 1 while blocked; GO_LO1 begins on the cycle after bit 1 drops.
REQ-033 rst asserted on the 2nd cycle of GO_LO2 -> go_n=1 next cycle, cursor=1, busy=0; no further presses until enable.
REQ-034 enable dropped during WAIT_FREE at cursor=5 with lane blocked -> IDLE, cursor=5; re-enable with lane free -> press sequence at cursor 5.
REQ-035 BACKOFF_EN, cursor=5, outview[5]=1 held -> after 20 blocked cycles back_n low 4 cycles, cursor=3; without macro back_n stays 1 and cursor stays 5.
REQ-036 All scenarios: assert go_n and back_n never both 0.
